// File: rtl/edge_det_pkg.sv
// rtl/edge_det_pkg.sv - shared types and constants for edge_det_multi
package edge_det_pkg;

  // Per-channel edge selection
  typedef enum logic [1:0] {
    EDGE_OFF  = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2,
    EDGE_BOTH = 2'd3
  } edge_mode_e;

  // Smallest legal parameter values
  localparam int MIN_NUM_CH      = 1;
  localparam int MIN_SYNC_STAGES = 2;
  localparam int MIN_FILT_CYCLES = 1;
  localparam int MIN_CNT_W       = 1;

  // Counter maximum for the default counter width
  localparam int DEFAULT_CNT_W   = 8;
  localparam int DEFAULT_CNT_MAX = (1 << DEFAULT_CNT_W) - 1;

  function automatic logic rise_enabled(input edge_mode_e mode);
    return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
  endfunction

  function automatic logic fall_enabled(input edge_mode_e mode);
    return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// rtl/edge_det_chan.sv - one channel: sync, glitch filter, edge pulses, sticky flag, counter
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8,
  parameter bit RST_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_i,
  input  edge_mode_e       mode_i,
  input  logic             clr_i,
  output logic             rising_o,
  output logic             falling_o,
  output logic             level_o,
  output logic             sticky_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int               FW        = $clog2(FILT_CYCLES + 1);
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic                   level_q, level_d;
  logic                   level_prev_q;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   s;
  logic                   pulse;

  assign s      = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], a_i};
  assign pulse  = rise_q | fall_q;

  // Filter: a new level must be seen FILT_CYCLES samples in a row before it is accepted
  always_comb begin
    fcnt_d  = '0;
    level_d = level_q;
    if (s != level_q) begin
      if (fcnt_q == FILT_LAST) begin
        level_d = s;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Edge decision against the previous filtered level, gated by the current mode
  always_comb begin
    rise_d = level_q & ~level_prev_q & rise_enabled(mode_i);
    fall_d = ~level_q & level_prev_q & fall_enabled(mode_i);
  end

  // Sticky flag and saturating counter; a pulse in the clear cycle still counts
  always_comb begin
    sticky_d = clr_i ? pulse : (sticky_q | pulse);
    cnt_d    = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_W'(pulse);
    end else if (pulse && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= {SYNC_STAGES{RST_LEVEL}};
      fcnt_q       <= '0;
      level_q      <= RST_LEVEL;
      level_prev_q <= RST_LEVEL;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      sticky_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync_q       <= sync_d;
      fcnt_q       <= fcnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      sticky_q     <= sticky_d;
      cnt_q        <= cnt_d;
    end
  end

  assign rising_o  = rise_q;
  assign falling_o = fall_q;
  assign level_o   = level_q;
  assign sticky_o  = sticky_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/edge_det_multi.sv
// rtl/edge_det_multi.sv - multi-channel filtered edge detector with aggregate interrupt
module edge_det_multi
  import edge_det_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8,
  parameter bit RST_LEVEL   = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       a_i,
  input  logic [2*NUM_CH-1:0]     mode_i,
  input  logic [NUM_CH-1:0]       clr_i,
  output logic [NUM_CH-1:0]       rising_edge,
  output logic [NUM_CH-1:0]       falling_edge,
  output logic [NUM_CH-1:0]       level_o,
  output logic [NUM_CH-1:0]       evt_sticky_o,
  output logic [NUM_CH*CNT_W-1:0] evt_cnt_o,
  output logic                    irq_o
);

  if (NUM_CH < MIN_NUM_CH) begin : g_bad_num_ch
    $error("edge_det_multi: NUM_CH must be at least 1");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $error("edge_det_multi: SYNC_STAGES must be at least 2");
  end
  if (FILT_CYCLES < MIN_FILT_CYCLES) begin : g_bad_filt
    $error("edge_det_multi: FILT_CYCLES must be at least 1");
  end
  if (CNT_W < MIN_CNT_W) begin : g_bad_cnt
    $error("edge_det_multi: CNT_W must be at least 1");
  end

  logic irq_q, irq_d;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    edge_det_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES),
      .CNT_W      (CNT_W),
      .RST_LEVEL  (RST_LEVEL)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .a_i      (a_i[n]),
      .mode_i   (edge_mode_e'(mode_i[2*n +: 2])),
      .clr_i    (clr_i[n]),
      .rising_o (rising_edge[n]),
      .falling_o(falling_edge[n]),
      .level_o  (level_o[n]),
      .sticky_o (evt_sticky_o[n]),
      .cnt_o    (evt_cnt_o[n*CNT_W +: CNT_W])
    );
  end

  assign irq_d = |evt_sticky_o;

  // Registered interrupt so the controller sees a clean flop output
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_edge_det_multi.sv
// tb/tb_edge_det_multi.sv - self-checking bench for edge_det_multi
module tb_edge_det_multi;
  import edge_det_pkg::*;

  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_CYCLES = 4;
  localparam int CNT_W       = 2;
  // Input driven after edge N is first sampled at edge N+1 (E0); pulse visible after E0+6
  localparam int LAT         = 7;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [NUM_CH-1:0]       a_i = '0;
  logic [2*NUM_CH-1:0]     mode_i = '0;
  logic [NUM_CH-1:0]       clr_i = '0;
  logic [NUM_CH-1:0]       rising_edge, falling_edge, level_o, evt_sticky_o;
  logic [NUM_CH*CNT_W-1:0] evt_cnt_o;
  logic                    irq_o;

  edge_det_multi #(
    .NUM_CH(NUM_CH), .SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES),
    .CNT_W(CNT_W), .RST_LEVEL(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .a_i(a_i), .mode_i(mode_i), .clr_i(clr_i),
    .rising_edge(rising_edge), .falling_edge(falling_edge), .level_o(level_o),
    .evt_sticky_o(evt_sticky_o), .evt_cnt_o(evt_cnt_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    bit rise;
    int at;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  // Pop an expected pulse for every pulse the DUT shows; flag strays and overdue entries
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int d = 0; d < 2; d++) begin
          automatic bit p = (d == 0) ? rising_edge[c] : falling_edge[c];
          automatic int idx = -1;
          if (p) begin
            for (int k = 0; k < sb.size(); k++)
              if (idx < 0 && sb[k].ch == c && sb[k].rise == (d == 0)) idx = k;
            n_cmp++;
            if (idx < 0) begin
              n_err++;
              $display("FAIL unexpected_pulse: ch%0d %s at cycle %0d, required none",
                       c, (d == 0) ? "rise" : "fall", cyc);
            end else begin
              if (sb[idx].at !== cyc) begin
                n_err++;
                $display("FAIL pulse_cycle: ch%0d %s at cycle %0d, required %0d",
                         c, (d == 0) ? "rise" : "fall", cyc, sb[idx].at);
              end
              sb.delete(idx);
            end
          end
        end
      end
      for (int k = sb.size() - 1; k >= 0; k--) begin
        if (sb[k].at < cyc) begin
          n_cmp++;
          n_err++;
          $display("FAIL missing_pulse: ch%0d %s not seen, required at cycle %0d",
                   sb[k].ch, sb[k].rise ? "rise" : "fall", sb[k].at);
          sb.delete(k);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Drive one channel and queue the pulse the current mode should produce
  task automatic set_a(input int ch, input bit v);
    logic [1:0] m;
    m = mode_i[2*ch +: 2];
    if (a_i[ch] !== v) begin
      a_i[ch] = v;
      if ((v && (m == 2'd1 || m == 2'd3)) || (!v && (m == 2'd2 || m == 2'd3)))
        sb.push_back('{ch, v, cyc + LAT});
    end
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return evt_cnt_o[ch*CNT_W +: CNT_W];
  endfunction

  task automatic test_reset();
    reset = 1'b1; a_i = '1; clr_i = '0; mode_i = 8'hFF;
    mon_en = 1'b1;
    step(3);
    n_cmp++;
    if ({rising_edge, falling_edge, level_o, evt_sticky_o, evt_cnt_o, irq_o} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got r=%h f=%h l=%h s=%h c=%h i=%b, required all zero",
               rising_edge, falling_edge, level_o, evt_sticky_o, evt_cnt_o, irq_o);
    end
    reset = 1'b0;
    for (int c = 0; c < NUM_CH; c++) sb.push_back('{c, 1'b1, cyc + LAT});
    step(LAT);
    n_cmp++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL release_pulses: %0d pending, required 0", sb.size());
    end
    step(1);
    n_cmp++;
    if (evt_sticky_o !== 4'hF || irq_o !== 1'b0) begin
      n_err++;
      $display("FAIL release_sticky: sticky=%h irq=%b, required F/0", evt_sticky_o, irq_o);
    end
    n_cmp++;
    if (evt_cnt_o !== 8'h55) begin
      n_err++;
      $display("FAIL release_cnt: got %h, required 55", evt_cnt_o);
    end
    step(1);
    n_cmp++;
    if (irq_o !== 1'b1) begin
      n_err++;
      $display("FAIL release_irq: got %b, required 1", irq_o);
    end
    mode_i = '0; a_i = '0;
    step(12);
    clr_i = '1; step(1); clr_i = '0;
    n_cmp++;
    if (evt_sticky_o !== 4'h0 || evt_cnt_o !== 8'h00) begin
      n_err++;
      $display("FAIL release_clear: sticky=%h cnt=%h, required 0/00", evt_sticky_o, evt_cnt_o);
    end
    step(3);
  endtask

  task automatic test_glitch();
    mode_i = 8'h01;
    a_i[0] = 1'b1; step(3); a_i[0] = 1'b0;
    step(12);
    n_cmp++;
    if (level_o[0] !== 1'b0 || cnt_of(0) !== 2'd0) begin
      n_err++;
      $display("FAIL glitch_suppress: level=%b cnt=%0d, required 0/0", level_o[0], cnt_of(0));
    end
    set_a(0, 1'b1); step(4); set_a(0, 1'b0);
    step(15);
    n_cmp++;
    if (cnt_of(0) !== 2'd1 || level_o[0] !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_accept: cnt=%0d level=%b, required 1/0", cnt_of(0), level_o[0]);
    end
  endtask

  task automatic test_fall_only();
    mode_i = 8'h08;
    set_a(1, 1'b1); step(10);
    set_a(1, 1'b0); step(10);
    set_a(1, 1'b1); step(10);
    n_cmp++;
    if (cnt_of(1) !== 2'd1) begin
      n_err++;
      $display("FAIL fall_only_cnt: got %0d, required 1", cnt_of(1));
    end
  endtask

  task automatic test_saturate();
    logic [CNT_W-1:0] exp_c;
    mode_i = 8'h30;
    for (int i = 0; i < 5; i++) begin
      set_a(2, ~a_i[2]);
      step(10);
      exp_c = (i + 1 > 3) ? 2'd3 : CNT_W'(i + 1);
      n_cmp++;
      if (cnt_of(2) !== exp_c) begin
        n_err++;
        $display("FAIL saturate_%0d: got %0d, required %0d", i, cnt_of(2), exp_c);
      end
    end
  endtask

  task automatic test_clr_collide();
    mode_i = 8'hC0;
    clr_i = '1; step(1); clr_i = '0; step(2);
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_err++;
      $display("FAIL clr_all_irq: got %b, required 0", irq_o);
    end
    set_a(3, 1'b1); step(LAT);
    clr_i[3] = 1'b1; step(1); clr_i[3] = 1'b0;
    n_cmp++;
    if (evt_sticky_o[3] !== 1'b1 || cnt_of(3) !== 2'd1) begin
      n_err++;
      $display("FAIL clr_collide: sticky=%b cnt=%0d, required 1/1", evt_sticky_o[3], cnt_of(3));
    end
    step(1);
    n_cmp++;
    if (irq_o !== 1'b1) begin
      n_err++;
      $display("FAIL collide_irq: got %b, required 1", irq_o);
    end
    step(1);
    clr_i[3] = 1'b1; step(1); clr_i[3] = 1'b0;
    n_cmp++;
    if (evt_sticky_o[3] !== 1'b0 || cnt_of(3) !== 2'd0 || irq_o !== 1'b1) begin
      n_err++;
      $display("FAIL clr_alone: sticky=%b cnt=%0d irq=%b, required 0/0/1",
               evt_sticky_o[3], cnt_of(3), irq_o);
    end
    step(1);
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_err++;
      $display("FAIL clr_irq_fall: got %b, required 0", irq_o);
    end
  endtask

  task automatic test_reset_mid();
    mode_i = 8'hFF;
    set_a(0, 1'b1); step(4);
    reset = 1'b1; a_i = '0; sb.delete();
    step(1);
    n_cmp++;
    if ({rising_edge, falling_edge, level_o, evt_sticky_o, evt_cnt_o, irq_o} !== '0) begin
      n_err++;
      $display("FAIL mid_filter_reset: r=%h f=%h l=%h s=%h c=%h i=%b, required all zero",
               rising_edge, falling_edge, level_o, evt_sticky_o, evt_cnt_o, irq_o);
    end
    step(2); reset = 1'b0; step(20);
    n_cmp++;
    if (sb.size() !== 0 || level_o !== 4'h0 || evt_cnt_o !== 8'h00) begin
      n_err++;
      $display("FAIL mid_filter_after: pend=%0d level=%h cnt=%h, required 0/0/00",
               sb.size(), level_o, evt_cnt_o);
    end
    set_a(1, 1'b1); step(LAT);
    n_cmp++;
    if (rising_edge[1] !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pulse_seen: got %b, required 1", rising_edge[1]);
    end
    reset = 1'b1; a_i = '0;
    step(1);
    n_cmp++;
    if ({rising_edge, falling_edge, level_o, evt_sticky_o, evt_cnt_o, irq_o} !== '0) begin
      n_err++;
      $display("FAIL mid_pulse_reset: r=%h f=%h l=%h s=%h c=%h i=%b, required all zero",
               rising_edge, falling_edge, level_o, evt_sticky_o, evt_cnt_o, irq_o);
    end
    reset = 1'b0; step(20);
    n_cmp++;
    if (sb.size() !== 0 || evt_sticky_o !== 4'h0 || irq_o !== 1'b0) begin
      n_err++;
      $display("FAIL mid_pulse_after: pend=%0d sticky=%h irq=%b, required 0/0/0",
               sb.size(), evt_sticky_o, irq_o);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_fall_only();
    test_saturate();
    test_clr_collide();
    test_reset_mid();
    step(2);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
